button_bounce_gen: RTL and testbench



---
 rtl/button_bounce_gen.sv | 140 ++++++++++++++
 tb/tb_button_bounce_gen.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_bounce_gen.sv
// Pushbutton emulator: bouncy press, stable hold, bouncy release, one-clk done; pb_o rises 1 clk after accept, requests while busy are dropped.
// Define BOUNCE_GEN_LFSR_EN for pseudo-random gaps 1..GAP_MAX from a 16-bit Galois LFSR; otherwise every gap is GAP_MAX ticks.
module button_bounce_gen #(
   parameter int          DIV_TIMES  = 100,
   parameter int          BOUNCE_NUM = 3,
   parameter int          GAP_MAX    = 8,
   parameter int          HOLD_TICKS = 32,
   parameter logic [15:0] SEED       = 16'hACE1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       press_req,
   output logic       pb_o,
   output logic       busy,
   output logic       done,
   output logic [7:0] edges_o
);

   localparam int          PW         = (DIV_TIMES > 1) ? $clog2(DIV_TIMES) : 1;
   localparam int          GW         = $clog2(GAP_MAX);
   localparam logic [6:0]  EDGES_INIT = 7'(2 * BOUNCE_NUM);
   localparam logic [15:0] HOLD_INIT  = (HOLD_TICKS == 0) ? 16'd1 : 16'(HOLD_TICKS);

   typedef enum logic [2:0] {IDLE, PRESS, HOLD, RELEASE, DONE} state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] div_q, div_d;
   logic          pb_q, pb_d;
   logic [7:0]    edges_q, edges_d;
   logic [6:0]    left_q, left_d;
   logic [8:0]    gap_q, gap_d;
   logic [15:0]   hold_q, hold_d;
   logic          tick;
   logic [8:0]    gap_val;
   logic [7:0]    edges_inc;

   assign div_d     = (div_q == PW'(DIV_TIMES - 1)) ? '0 : div_q + PW'(1);
   assign tick      = (div_q == PW'(DIV_TIMES - 1));
   assign edges_inc = (edges_q == 8'hFF) ? edges_q : edges_q + 8'd1;

`ifdef BOUNCE_GEN_LFSR_EN
   localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
   logic [15:0] lfsr_q, lfsr_d;
   logic        reload;

   // Mirrors every gap_cnt reload in the FSM below so the LFSR steps once per gap.
   assign reload = ((state_q == IDLE) && press_req) ||
                   (tick && ((state_q == PRESS) || (state_q == RELEASE)) &&
                    (gap_q <= 9'd1) && (left_q != 7'd0)) ||
                   (tick && (state_q == HOLD) && (hold_q == 16'd1));
   assign lfsr_d  = reload ? ({1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000)) : lfsr_q;
   assign gap_val = {{(9 - GW){1'b0}}, lfsr_q[GW-1:0]} + 9'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) lfsr_q <= SEED_EFF;
      else     lfsr_q <= lfsr_d;
   end
`else
   assign gap_val = 9'(GAP_MAX);
`endif

   always_comb begin
      state_d = state_q;
      pb_d    = pb_q;
      edges_d = edges_q;
      left_d  = left_q;
      gap_d   = gap_q;
      hold_d  = hold_q;
      case (state_q)
         IDLE: begin
            if (press_req) begin
               pb_d    = 1'b1;
               edges_d = 8'd1;
               left_d  = EDGES_INIT;
               gap_d   = gap_val;
               state_d = PRESS;
            end
         end
         PRESS, RELEASE: begin
            if (tick) begin
               if (gap_q > 9'd1) begin
                  gap_d = gap_q - 9'd1;
               end else if (left_q != 7'd0) begin
                  pb_d    = ~pb_q;
                  left_d  = left_q - 7'd1;
                  edges_d = edges_inc;
                  gap_d   = gap_val;
               end else if (state_q == PRESS) begin
                  // Even toggle count after the first edge leaves pb high here.
                  hold_d  = HOLD_INIT;
                  state_d = HOLD;
               end else begin
                  state_d = DONE;
               end
            end
         end
         HOLD: begin
            if (tick) begin
               if (hold_q == 16'd1) begin
                  pb_d    = 1'b0;
                  edges_d = edges_inc;
                  left_d  = EDGES_INIT;
                  gap_d   = gap_val;
                  state_d = RELEASE;
               end else begin
                  hold_d = hold_q - 16'd1;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         div_q   <= '0;
         pb_q    <= 1'b0;
         edges_q <= 8'd0;
         left_q  <= 7'd0;
         gap_q   <= 9'd0;
         hold_q  <= 16'd0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         pb_q    <= pb_d;
         edges_q <= edges_d;
         left_q  <= left_d;
         gap_q   <= gap_d;
         hold_q  <= hold_d;
      end
   end

   assign pb_o    = pb_q;
   assign busy    = (state_q != IDLE);
   assign done    = (state_q == DONE);
   assign edges_o = edges_q;

endmodule

// File: tb/tb_button_bounce_gen.sv
// Directed bench for button_bounce_gen: edge timing, back-to-back requests, clean single-edge mode, async reset abort, repeatability.
module tb_button_bounce_gen;

`ifdef BOUNCE_GEN_LFSR_EN
   localparam int GAP_A = 8;
`else
   localparam int GAP_A = 4;
`endif
   // Gap lengths in clk (4 clk per tick).
   localparam int T_MIN = (GAP_A == 8) ? 4 : 16;
   localparam int T_MAX = GAP_A * 4;
   localparam int HOLD_CLK = 32;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_a = 1'b0, req_b = 1'b0;
   logic       pb_a, busy_a, done_a, pb_b, busy_b, done_b;
   logic [7:0] edges_a, edges_b;

   int n_chk = 0;
   int n_fail = 0;
   int edge_cyc [64];
   int run1_cyc [64];
   int n_edges, done_cyc, run1_n, run1_done;

   logic deb = 1'b0;
   int   stab = 0;
   int   deb_rises = 0;

   always #5 clk = ~clk;

   button_bounce_gen #(.DIV_TIMES(4), .BOUNCE_NUM(2), .GAP_MAX(GAP_A), .HOLD_TICKS(8), .SEED(16'hACE1)) u_a (
      .clk(clk), .rst(rst), .press_req(req_a), .pb_o(pb_a), .busy(busy_a), .done(done_a), .edges_o(edges_a));

   button_bounce_gen #(.DIV_TIMES(4), .BOUNCE_NUM(0), .GAP_MAX(GAP_A), .HOLD_TICKS(0), .SEED(16'hACE1)) u_b (
      .clk(clk), .rst(rst), .press_req(req_b), .pb_o(pb_b), .busy(busy_b), .done(done_b), .edges_o(edges_b));

   // Simple stability-count debouncer watching u_a.
   always @(posedge clk) begin
      if (rst) begin
         deb  = 1'b0;
         stab = 0;
      end else if (pb_a == deb) begin
         stab = 0;
      end else begin
         stab++;
         if (stab >= 24) begin
            if (pb_a) deb_rises++;
            deb  = pb_a;
            stab = 0;
         end
      end
   end

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_pb_a", pb_a, 0);
      check("rst_busy_a", busy_a, 0);
      check("rst_done_a", done_a, 0);
      check("rst_edges_a", edges_a, 0);
      check("rst_pb_b", pb_b, 0);
      check("rst_busy_b", busy_b, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // Raises the request, records the cycle of every pb transition and of done.
   task automatic measure(input bit sel, input bit hold_req, input int budget);
      logic cur, prev;
      n_edges  = 0;
      done_cyc = -1;
      prev     = 1'b0;
      if (sel) req_b = 1'b1;
      else     req_a = 1'b1;
      for (int c = 1; c <= budget; c++) begin
         @(posedge clk);
         #1;
         if (!hold_req) begin
            req_a = 1'b0;
            req_b = 1'b0;
         end
         cur = sel ? pb_b : pb_a;
         if (cur != prev && n_edges < 64) begin
            edge_cyc[n_edges] = c;
            n_edges++;
         end
         prev = cur;
         if ((sel ? done_b : done_a) == 1'b1) begin
            done_cyc = c;
            break;
         end
      end
      check("done_seen", int'(done_cyc > 0), 1);
   endtask

   task automatic check_a_timing(input string tag);
      int d;
      check({tag, "_n_edges"}, n_edges, 10);
      check({tag, "_rise_lat"}, edge_cyc[0], 1);
      if (n_edges == 10) begin
         d = edge_cyc[1] - edge_cyc[0];
         check({tag, "_gap_first"}, int'(d >= T_MIN - 3 && d <= T_MAX), 1);
         for (int i = 2; i < 10; i++) begin
            d = edge_cyc[i] - edge_cyc[i-1];
            if (i == 5) check({tag, "_hold"}, int'(d >= T_MIN + HOLD_CLK && d <= T_MAX + HOLD_CLK && d % 4 == 0), 1);
            else        check({tag, "_gap"}, int'(d >= T_MIN && d <= T_MAX && d % 4 == 0), 1);
         end
         d = done_cyc - edge_cyc[9];
         check({tag, "_done_gap"}, int'(d >= T_MIN && d <= T_MAX), 1);
      end
   endtask

   initial begin
      int d, rises0, budget;

      // Single press, pulsed request.
      do_reset();
      rises0 = deb_rises;
      measure(1'b0, 1'b0, 1000);
      check_a_timing("op1");
      check("op1_edges_o", edges_a, 10);
      check("op1_done_pb", pb_a, 0);
      run1_n    = n_edges;
      run1_done = done_cyc;
      for (int i = 0; i < 64; i++) run1_cyc[i] = edge_cyc[i];
      @(posedge clk); #1;
      check("op1_done_1clk", done_a, 0);
      check("op1_busy_after", busy_a, 0);
      check("op1_edges_hold", edges_a, 10);
`ifndef BOUNCE_GEN_LFSR_EN
      check("deb_one_pulse", deb_rises - rises0, 1);
`endif

      // Back-to-back: request held through the whole operation.
      repeat (3) @(posedge clk); #1;
      measure(1'b0, 1'b1, 1000);
      check("b2b_edges_at_done", edges_a, 10);
      check("b2b_n_edges", n_edges, 10);
      @(posedge clk); #1;
      check("b2b_idle_busy", busy_a, 0);
      check("b2b_idle_pb", pb_a, 0);
      @(posedge clk); #1;
      check("b2b_restart_pb", pb_a, 1);
      check("b2b_restart_edges", edges_a, 1);
      req_a = 1'b0;
      budget = 1000;
      while (!done_a && budget > 0) begin
         @(posedge clk); #1;
         budget--;
      end
      check("b2b_second_done", done_a, 1);
      check("b2b_second_edges", edges_a, 10);

      // Clean single-edge mode.
      repeat (2) @(posedge clk); #1;
      measure(1'b1, 1'b0, 1000);
      check("b_n_edges", n_edges, 2);
      check("b_rise_lat", edge_cyc[0], 1);
      d = edge_cyc[1] - edge_cyc[0];
      check("b_hold", int'(d >= T_MIN + 1 && d <= T_MAX + 4), 1);
      d = done_cyc - edge_cyc[1];
      check("b_done_gap", int'(d >= T_MIN && d <= T_MAX), 1);
      check("b_edges_o", edges_b, 2);

      // Asynchronous reset while holding.
      repeat (2) @(posedge clk); #1;
      req_a = 1'b1;
      @(posedge clk); #1;
      req_a = 1'b0;
      budget = 1000;
      while (edges_a != 8'd5 && budget > 0) begin
         @(posedge clk); #1;
         budget--;
      end
      check("rh_reach_5", edges_a, 5);
      repeat (34) @(posedge clk);
      #1;
      check("rh_in_hold_pb", pb_a, 1);
      check("rh_in_hold_edges", edges_a, 5);
      #2;
      rst = 1'b1;
      #1;
      check("rh_async_pb", pb_a, 0);
      check("rh_async_busy", busy_a, 0);
      check("rh_async_edges", edges_a, 0);
      d = 0;
      repeat (3) begin
         @(posedge clk); #1;
         d += done_a;
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         d += done_a;
      end
      check("rh_no_done", d, 0);
      measure(1'b0, 1'b0, 1000);
      check_a_timing("rh_after");
      check("rh_after_edges_o", edges_a, 10);

      // Same stimulus from reset must give the same waveform.
      do_reset();
      measure(1'b0, 1'b0, 1000);
      check("rep_n_edges", n_edges, run1_n);
      check("rep_done_cyc", done_cyc, run1_done);
      d = 0;
      for (int i = 0; i < run1_n && i < 64; i++) if (edge_cyc[i] != run1_cyc[i]) d++;
      check("rep_edge_cycles", d, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
